mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register for the 5-stage MIPS core.
- Consumes the EX/MEM register outputs: PC, PC8, ALUOUT, RD2 and INSTR.
- Decodes the load/store opcode from INSTR, performs word/half/byte access to an internal data memory, and registers everything the WB stage needs, including extended load data and an alignment-exception flag.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- DM_AW, 10, word-index width; must equal log2(DM_WORDS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  high = hold MEM/WB register and suppress memory writes.
- pc  in  32  instruction PC from EX/MEM.
- pc8  in  32  PC+8 (link value) from EX/MEM.
- aluout  in  32  effective address or ALU result.
- rd2  in  32  store data, already forwarded.
- instr  in  32  instruction word.
- PC_W  out  32  registered pc.
- PC8_W  out  32  registered pc8.
- ALUOUT_W  out  32  registered aluout.
- DMOUT_W  out  32  registered, extended load data.
- INSTR_W  out  32  registered instr.
- EXC_W  out  2  registered exception code: 0 none, 1 load misaligned, 2 store misaligned.

Behaviour:
- Reset (reset=0, asynchronous): all *_W outputs go to 0 immediately; every data-memory word is cleared to 0. Reset is released synchronously to the next clk edge.
- Opcode decode, instr[31:26]:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Any other opcode is neither a load nor a store.
- Addressing:
  - Word index is aluout[DM_AW+1:2]; upper address bits are ignored, so addresses wrap modulo DM_WORDS*4.
  - Byte lane is aluout[1:0]. Little-endian: byte k occupies bits 8k+7:8k; a halfword at offset 0 uses bits 15:0, at offset 2 uses bits 31:16.
- Alignment:
  - lw/sw require aluout[1:0]=00; lh/lhu/sh require aluout[0]=0; byte accesses are always aligned.
  - Misaligned load: DMOUT_W=0 and EXC_W=1.
  - Misaligned store: no memory write and EXC_W=2.
- Store (posedge clk, reset=1, stall=0, aligned):
  - sw writes the full word.
  - sh writes rd2[15:0] into the addressed half.
  - sb writes rd2[7:0] into the addressed byte.
  - Unaddressed bytes are preserved (read-modify-write of the lane mask).
  - Simulation only: $display("%d@%h: *%h <= %h", $time, pc, {aluout[31:2],2'b00}, new_word), where new_word is the full merged word.
- Load:
  - Combinational read of the current word, lane select, then sign extension (lh, lb) or zero extension (lhu, lbu).
  - The result is captured into DMOUT_W at the same edge as the other MEM/WB fields, so WB sees the data 1 cycle after the load sits in MEM.
  - Non-load instructions register DMOUT_W=0.
- Store-then-load: a store in cycle N followed by a load to the same word in cycle N+1 returns the updated value; the memory write completes at the edge ending cycle N.
- Stall=1:
  - All *_W outputs hold their values.
  - Memory writes are suppressed, so a store repeated while stalled writes exactly once, on the first unstalled edge.
- Reset asserted mid-operation: any in-flight store that has not reached a clock edge is dropped, and memory clears.

Decomposition:
- Shared package/header holds the opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB) and the EXC_NONE/EXC_ADEL/EXC_ADES codes. The decode stage reuses the same constants.
- One natural sub-module: dm_byte_ram. It holds the memory array, the byte-enable write and the asynchronous clear, and exposes the read word. The stage wraps it with decode, lane logic, extension and the MEM/WB register.

Test Plan:
1. sw with rd2=0x12345678, aluout=0x10, then lw from 0x10 -> DMOUT_W=0x12345678, EXC_W=0; $display shows *00000010 <= 12345678.
2. sb rd2=0x000000F0 to 0x13, then lb 0x13 -> 0xFFFFFFF0; lbu 0x13 -> 0x000000F0; lw 0x10 -> 0xF0345678.
3. sh rd2=0x8001 to 0x12, then lh 0x12 -> 0xFFFF8001 and lhu 0x12 -> 0x00008001. sh to 0x11 -> no write, EXC_W=2; lw 0x11 -> DMOUT_W=0, EXC_W=1.
4. Assert stall for 3 cycles while sw 0x20 (0xAAAA5555) is held at the inputs -> *_W frozen and no write until stall drops; then exactly one write occurs, followed by one $display.
5. Address wrap: sw 0xDEADBEEF to aluout=0x1000 (DM_WORDS=1024) -> lw 0x0 returns 0xDEADBEEF.
6. Drive reset low mid-clock-period after several stores -> all *_W read 0 before the next edge; lw 0x10 after release returns 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: load/store opcodes, exception codes and access-size decode shared by decode and MEM stages
package mem_wb_stage_pkg;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;

  typedef enum logic [1:0] {SZ_NONE, SZ_W, SZ_H, SZ_B} acc_size_e;

  function automatic logic is_load(input logic [5:0] op);
    return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SW || op == OP_SH || op == OP_SB;
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return op == OP_LH || op == OP_LB;
  endfunction

  function automatic acc_size_e acc_size(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? SZ_W :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_H :
           (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_B : SZ_NONE;
  endfunction

  function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] lane);
    return sz == SZ_W ? lane == 2'b00 : sz == SZ_H ? !lane[0] : 1'b1;
  endfunction
endpackage

// File: rtl/mem_wb_stage_dm_byte_ram.sv
// dm_byte_ram: word-addressed data memory with per-byte write enables,
// asynchronous read and asynchronous clear of every word.
module dm_byte_ram #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DM_AW-1:0] i_addr,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);
  logic [31:0] r_mem [DM_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory stage (load/store decode, lane logic, extension)
// plus the MEM/WB pipeline register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [31:0] pc8,
  input  logic [31:0] aluout,
  input  logic [31:0] rd2,
  input  logic [31:0] instr,
  output logic [31:0] PC_W,
  output logic [31:0] PC8_W,
  output logic [31:0] ALUOUT_W,
  output logic [31:0] DMOUT_W,
  output logic [31:0] INSTR_W,
  output logic [1:0]  EXC_W
);
  logic [5:0]  w_op;
  logic [1:0]  w_lane;
  acc_size_e   w_size;
  logic        w_load, w_store, w_aligned, w_sgn, w_we;
  logic [3:0]  w_be;
  logic [31:0] w_mask, w_wdata, w_rdata, w_new_word, w_shift, w_ext, w_dmout;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [1:0]  w_exc;

  logic [31:0] r_pc, r_pc8, r_aluout, r_dmout, r_instr;
  logic [1:0]  r_exc;

  assign w_op      = instr[31:26];
  assign w_lane    = aluout[1:0];
  assign w_size    = acc_size(w_op);
  assign w_load    = is_load(w_op);
  assign w_store   = is_store(w_op);
  assign w_sgn     = is_signed_load(w_op);
  assign w_aligned = is_aligned(w_size, w_lane);
  assign w_we      = w_store && w_aligned && !stall;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    w_be    = w_size == SZ_W ? 4'hf : w_size == SZ_H ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_lane;
    w_wdata = w_size == SZ_W ? rd2 : w_size == SZ_H ? {2{rd2[15:0]}} : {4{rd2[7:0]}};
    w_mask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  end

  assign w_new_word = (w_rdata & ~w_mask) | (w_wdata & w_mask);

  dm_byte_ram #(.DM_WORDS(DM_WORDS), .DM_AW(DM_AW)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_addr  (aluout[DM_AW+1:2]),
    .i_be    (w_we ? w_be : 4'h0),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_shift = w_rdata >> {w_lane, 3'b000};
    w_half  = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_byte  = w_shift[7:0];
    w_ext   = w_size == SZ_W ? w_rdata :
              w_size == SZ_H ? {{16{w_sgn & w_half[15]}}, w_half} : {{24{w_sgn & w_byte[7]}}, w_byte};
    w_dmout = (w_load && w_aligned) ? w_ext : 32'h0;
    w_exc   = (w_load && !w_aligned) ? EXC_ADEL : (w_store && !w_aligned) ? EXC_ADES : EXC_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_pc8    <= '0;
      r_aluout <= '0;
      r_dmout  <= '0;
      r_instr  <= '0;
      r_exc    <= EXC_NONE;
    end else if (!stall) begin
      r_pc     <= pc;
      r_pc8    <= pc8;
      r_aluout <= aluout;
      r_dmout  <= w_dmout;
      r_instr  <= instr;
      r_exc    <= w_exc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && w_we) $display("%d@%h: *%h <= %h", $time, pc, {aluout[31:2], 2'b00}, w_new_word);
`endif

  assign PC_W     = r_pc;
  assign PC8_W    = r_pc8;
  assign ALUOUT_W = r_aluout;
  assign DMOUT_W  = r_dmout;
  assign INSTR_W  = r_instr;
  assign EXC_W    = r_exc;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of stores, loads, alignment, stall, wrap and reset.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 0, reset, stall;
  logic [31:0] pc, pc8, aluout, rd2, instr;
  logic [31:0] PC_W, PC8_W, ALUOUT_W, DMOUT_W, INSTR_W;
  logic [1:0]  EXC_W;
  logic [31:0] pc_n = 32'h0040_0000;
  logic [31:0] e_pc;
  int total = 0, bad = 0;

  mem_wb_stage #(.DM_WORDS(1024), .DM_AW(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc), .pc8(pc8), .aluout(aluout),
    .rd2(rd2), .instr(instr), .PC_W(PC_W), .PC8_W(PC8_W), .ALUOUT_W(ALUOUT_W),
    .DMOUT_W(DMOUT_W), .INSTR_W(INSTR_W), .EXC_W(EXC_W)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    instr = {op, 26'h0000ABC}; aluout = a; rd2 = d;
    pc = pc_n; pc8 = pc_n + 32'd8; pc_n = pc_n + 32'd4;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    set_in(op, a, d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 0; stall = 0;
    set_in(OP_LW, 32'h10, 32'h1);
    #2;
    total++; if ({PC_W, PC8_W, ALUOUT_W, DMOUT_W, INSTR_W, EXC_W} !== '0) begin
      bad++; $display("FAIL reset_initial pc=%h instr=%h dm=%h exc=%0d want all 0", PC_W, INSTR_W, DMOUT_W, EXC_W);
    end
    @(posedge clk); #1;
    total++; if ({PC_W, ALUOUT_W, INSTR_W} !== '0) begin
      bad++; $display("FAIL reset_held pc=%h alu=%h instr=%h want 0", PC_W, ALUOUT_W, INSTR_W);
    end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_word;
    e_pc = pc_n;
    drive(OP_SW, 32'h10, 32'h12345678);
    total++; if (PC_W !== e_pc || PC8_W !== e_pc + 32'd8 || ALUOUT_W !== 32'h10 || INSTR_W !== 32'hAC000ABC) begin
      bad++; $display("FAIL sw_fields pc=%h pc8=%h alu=%h instr=%h want %h/%h/00000010/ac000abc", PC_W, PC8_W, ALUOUT_W, INSTR_W, e_pc, e_pc + 32'd8);
    end
    total++; if (DMOUT_W !== 32'h0 || EXC_W !== 2'd0) begin
      bad++; $display("FAIL sw_dmout dm=%h exc=%0d want 0/0", DMOUT_W, EXC_W);
    end
    drive(OP_LW, 32'h10, 32'h0);
    total++; if (DMOUT_W !== 32'h12345678 || EXC_W !== 2'd0) begin
      bad++; $display("FAIL lw_word dm=%h exc=%0d want 12345678/0", DMOUT_W, EXC_W);
    end
  endtask

  task automatic test_byte;
    drive(OP_SB, 32'h13, 32'h000000F0);
    drive(OP_LB, 32'h13, 32'h0);
    total++; if (DMOUT_W !== 32'hFFFFFFF0) begin
      bad++; $display("FAIL lb dm=%h want fffffff0", DMOUT_W);
    end
    drive(OP_LBU, 32'h13, 32'h0);
    total++; if (DMOUT_W !== 32'h000000F0) begin
      bad++; $display("FAIL lbu dm=%h want 000000f0", DMOUT_W);
    end
    drive(OP_LW, 32'h10, 32'h0);
    total++; if (DMOUT_W !== 32'hF0345678) begin
      bad++; $display("FAIL lw_after_sb dm=%h want f0345678", DMOUT_W);
    end
    drive(OP_LBU, 32'h11, 32'h0);
    total++; if (DMOUT_W !== 32'h00000056) begin
      bad++; $display("FAIL lbu_lane1 dm=%h want 00000056", DMOUT_W);
    end
  endtask

  task automatic test_half;
    drive(OP_SH, 32'h12, 32'h00008001);
    drive(OP_LH, 32'h12, 32'h0);
    total++; if (DMOUT_W !== 32'hFFFF8001) begin
      bad++; $display("FAIL lh dm=%h want ffff8001", DMOUT_W);
    end
    drive(OP_LHU, 32'h12, 32'h0);
    total++; if (DMOUT_W !== 32'h00008001) begin
      bad++; $display("FAIL lhu dm=%h want 00008001", DMOUT_W);
    end
    drive(OP_LH, 32'h10, 32'h0);
    total++; if (DMOUT_W !== 32'h00005678) begin
      bad++; $display("FAIL lh_low dm=%h want 00005678", DMOUT_W);
    end
    drive(OP_SH, 32'h11, 32'h0000BEEF);
    total++; if (EXC_W !== 2'd2 || DMOUT_W !== 32'h0) begin
      bad++; $display("FAIL sh_misaligned exc=%0d dm=%h want 2/0", EXC_W, DMOUT_W);
    end
    drive(OP_LW, 32'h11, 32'h0);
    total++; if (EXC_W !== 2'd1 || DMOUT_W !== 32'h0) begin
      bad++; $display("FAIL lw_misaligned exc=%0d dm=%h want 1/0", EXC_W, DMOUT_W);
    end
    drive(OP_LW, 32'h10, 32'h0);
    total++; if (DMOUT_W !== 32'h80015678 || EXC_W !== 2'd0) begin
      bad++; $display("FAIL lw_after_sh dm=%h exc=%0d want 80015678/0", DMOUT_W, EXC_W);
    end
  endtask

  task automatic test_stall;
    stall = 1;
    set_in(OP_SW, 32'h20, 32'hAAAA5555);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (INSTR_W !== {OP_LW, 26'h0000ABC} || DMOUT_W !== 32'h80015678 || ALUOUT_W !== 32'h10) begin
        bad++; $display("FAIL stall_hold%0d instr=%h dm=%h alu=%h want 8c000abc/80015678/00000010", i, INSTR_W, DMOUT_W, ALUOUT_W);
      end
    end
    instr = 32'h0; stall = 0;
    @(posedge clk); #1;
    drive(OP_LW, 32'h20, 32'h0);
    total++; if (DMOUT_W !== 32'h0) begin
      bad++; $display("FAIL stall_no_write dm=%h want 00000000", DMOUT_W);
    end
    stall = 1;
    set_in(OP_SW, 32'h20, 32'hAAAA5555);
    repeat (3) @(posedge clk);
    #1 stall = 0;
    @(posedge clk); #1;
    total++; if (INSTR_W !== {OP_SW, 26'h0000ABC} || EXC_W !== 2'd0 || ALUOUT_W !== 32'h20) begin
      bad++; $display("FAIL stall_release instr=%h exc=%0d alu=%h want ac000abc/0/00000020", INSTR_W, EXC_W, ALUOUT_W);
    end
    drive(OP_LW, 32'h20, 32'h0);
    total++; if (DMOUT_W !== 32'hAAAA5555) begin
      bad++; $display("FAIL stall_write dm=%h want aaaa5555", DMOUT_W);
    end
  endtask

  task automatic test_wrap;
    drive(OP_SW, 32'h1000, 32'hDEADBEEF);
    drive(OP_LW, 32'h0, 32'h0);
    total++; if (DMOUT_W !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wrap dm=%h want deadbeef", DMOUT_W);
    end
    drive(OP_LBU, 32'hFFFF_F003, 32'h0);
    total++; if (DMOUT_W !== 32'h000000DE) begin
      bad++; $display("FAIL wrap_high dm=%h want 000000de", DMOUT_W);
    end
  endtask

  task automatic test_reset_mid;
    drive(OP_SW, 32'h30, 32'h11223344);
    set_in(OP_SW, 32'h34, 32'h55667788);
    #2 reset = 0;
    #1;
    total++; if ({PC_W, PC8_W, ALUOUT_W, DMOUT_W, INSTR_W, EXC_W} !== '0) begin
      bad++; $display("FAIL reset_mid pc=%h alu=%h dm=%h instr=%h exc=%0d want all 0", PC_W, ALUOUT_W, DMOUT_W, INSTR_W, EXC_W);
    end
    set_in(OP_LW, 32'h10, 32'h0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    total++; if (DMOUT_W !== 32'h0 || INSTR_W !== {OP_LW, 26'h0000ABC}) begin
      bad++; $display("FAIL reset_clear10 dm=%h instr=%h want 0/8c000abc", DMOUT_W, INSTR_W);
    end
    drive(OP_LW, 32'h34, 32'h0);
    total++; if (DMOUT_W !== 32'h0) begin
      bad++; $display("FAIL reset_drop_store dm=%h want 0", DMOUT_W);
    end
    drive(OP_LW, 32'h30, 32'h0);
    total++; if (DMOUT_W !== 32'h0) begin
      bad++; $display("FAIL reset_clear30 dm=%h want 0", DMOUT_W);
    end
  endtask

  task automatic test_back_to_back;
    drive(OP_SW, 32'h40, 32'hCAFEF00D);
    drive(OP_SB, 32'h41, 32'h00000099);
    drive(OP_LW, 32'h40, 32'h0);
    total++; if (DMOUT_W !== 32'hCAFE990D) begin
      bad++; $display("FAIL b2b dm=%h want cafe990d", DMOUT_W);
    end
    drive(32'h0, 32'h40, 32'h0);
    total++; if (DMOUT_W !== 32'h0 || EXC_W !== 2'd0) begin
      bad++; $display("FAIL nonmem dm=%h exc=%0d want 0/0", DMOUT_W, EXC_W);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_stall;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
